// File: rtl/weight_loader.sv
// Weight loader: pops one tile from the weight FIFO and streams its rows,
// highest index first, to the PE array. It then pulses w_commit so the PEs swap the tile to active.
module weight_loader #(
  parameter  int WEIGHT_BW   = 8,
  parameter  int NUM_PE_ROWS = 8,
  parameter  int MATRIX_SIZE = 8,
  localparam int ROW_W  = WEIGHT_BW * MATRIX_SIZE,
  localparam int TILE_W = ROW_W * NUM_PE_ROWS,
  localparam int IDX_W  = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [TILE_W-1:0] fifo_data,
  input  logic              w_ready,
  output logic [ROW_W-1:0]  w_row_out,
  output logic              w_row_valid,
  output logic [IDX_W-1:0]  w_row_idx,
  output logic              w_commit,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD, CAP, SHIFT, COMMIT} state_e;

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      cnt_q, cnt_d;
  logic [NUM_PE_ROWS-1:0][ROW_W-1:0]     tile_q, tile_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
    end
  end

  // Outputs depend only on state_q, cnt_q and tile_q, never on inputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tile_d      = tile_q;
    fifo_rd_en  = 1'b0;
    w_row_valid = 1'b0;
    w_row_idx   = '0;
    w_row_out   = '0;
    w_commit    = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start && !fifo_empty) state_d = RD;
      end
      RD: begin
        fifo_rd_en = 1'b1;
        state_d    = CAP;
      end
      CAP: begin
        // The FIFO read data is registered, so it becomes valid in the cycle after the strobe.
        tile_d  = fifo_data;
        cnt_d   = IDX_W'(NUM_PE_ROWS - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        w_row_valid = 1'b1;
        w_row_idx   = cnt_q;
        w_row_out   = tile_q[cnt_q];
        if (w_ready) begin
          if (cnt_q == '0) state_d = COMMIT;
          else             cnt_d   = cnt_q - IDX_W'(1);
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader. It uses a FIFO model and a stream-level reference
// model that predicts the row stream, the read strobes and the commit cycles.
module tb_weight_loader;
  localparam int W = 8, R = 8, M = 8;
  localparam int ROW_W = W * M, TILE_W = ROW_W * R, IDX_W = $clog2(R);

  logic              clk = 1'b0;
  logic              rstn, start, fifo_empty, fifo_rd_en, w_ready;
  logic              w_row_valid, w_commit, busy;
  logic [TILE_W-1:0] fifo_data;
  logic [ROW_W-1:0]  w_row_out;
  logic [IDX_W-1:0]  w_row_idx;

  always #5 clk = ~clk;

  weight_loader #(.WEIGHT_BW(W), .NUM_PE_ROWS(R), .MATRIX_SIZE(M)) dut (
    .clk(clk), .rstn(rstn), .start(start), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .w_ready(w_ready),
    .w_row_out(w_row_out), .w_row_valid(w_row_valid), .w_row_idx(w_row_idx),
    .w_commit(w_commit), .busy(busy));

  typedef struct {int cyc; int idx; logic [ROW_W-1:0] row;} vrec_t;

  logic [TILE_W-1:0] fq[$];
  vrec_t vlog[$], vexp[$];
  int    rdlog[$], cmlog[$];
  int    cyc = 0, base = 0, busy_hi = 0;
  bit    pat[$];
  int    checks = 0, errors = 0;

  function automatic bit rdy_at(int t);
    return (t - base >= 0 && t - base < pat.size()) ? pat[t - base] : 1'b1;
  endfunction

  function automatic logic [TILE_W-1:0] rand_tile();
    logic [TILE_W-1:0] t;
    for (int i = 0; i < TILE_W / 32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  // One clock: log this cycle's outputs, then advance. Pop the FIFO model if it was strobed.
  task automatic step();
    bit rd;
    rd = fifo_rd_en;
    if (fifo_rd_en)  rdlog.push_back(cyc);
    if (w_row_valid) vlog.push_back('{cyc, int'(w_row_idx), w_row_out});
    if (w_commit)    cmlog.push_back(cyc);
    if (busy)        busy_hi++;
    @(posedge clk); #1;
    cyc++;
    if (rd && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    w_ready    = rdy_at(cyc);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_logs();
    vlog.delete(); vexp.delete(); rdlog.delete(); cmlog.delete(); busy_hi = 0;
  endtask

  task automatic pulse_start(output int c);
    c = cyc; start = 1'b1; step(); start = 1'b0;
  endtask

  // Stream model: rows R-1..0 start two cycles after the strobe. A row repeats until ready is seen.
  task automatic model_load(input int c, input logic [TILE_W-1:0] tile, output int commit);
    int t, k;
    bit r;
    t = c + 3; k = R - 1;
    while (1) begin
      vexp.push_back('{t, k, tile[k*ROW_W +: ROW_W]});
      r = rdy_at(t); t++;
      if (r) begin
        if (k == 0) break;
        k--;
      end
    end
    commit = t;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; w_ready = 1'b1; fifo_empty = 1'b0; fifo_data = '1;
    run(2);
    checks++;
    if ({fifo_rd_en, w_row_valid, w_commit, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {fifo_rd_en, w_row_valid, w_commit, busy});
    end
    checks++;
    if (w_row_out !== '0 || w_row_idx !== '0) begin
      errors++; $display("FAIL reset_row: got row %h idx %0d want 0/0", w_row_out, w_row_idx);
    end
    rstn = 1'b1; start = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    run(2);
  endtask

  task automatic test_basic();
    logic [TILE_W-1:0] t;
    int c, cm;
    for (int r = 0; r < R; r++) for (int b = 0; b < M; b++) t[r*ROW_W + b*W +: W] = W'(r + 1);
    clr_logs(); pat.delete();
    fq.push_back(t); fifo_empty = 1'b0;
    pulse_start(c);
    model_load(c, t, cm);
    run(14);
    checks++;
    if (rdlog.size() !== 1 || rdlog[0] !== c + 1) begin
      errors++; $display("FAIL basic_rd: got %0d strobes first at %0d, want 1 at %0d", rdlog.size(), rdlog[0], c + 1);
    end
    checks++;
    if (vlog.size() !== vexp.size()) begin
      errors++; $display("FAIL basic_rows: got %0d valid cycles want %0d", vlog.size(), vexp.size());
    end
    foreach (vexp[i]) begin
      checks++;
      if (i >= vlog.size() || vlog[i].cyc !== vexp[i].cyc || vlog[i].idx !== vexp[i].idx || vlog[i].row !== vexp[i].row) begin
        errors++; $display("FAIL basic_row%0d: got idx %0d row %h want cyc %0d idx %0d row %h",
                           i, (i < vlog.size()) ? vlog[i].idx : -1, (i < vlog.size()) ? vlog[i].row : '0,
                           vexp[i].cyc, vexp[i].idx, vexp[i].row);
      end
    end
    checks++;
    if (cmlog.size() !== 1 || cmlog[0] !== c + 11) begin
      errors++; $display("FAIL basic_commit: got %0d pulses at %0d want 1 at %0d", cmlog.size(), cmlog[0], c + 11);
    end
  endtask

  task automatic test_empty();
    clr_logs();
    start = 1'b1; run(3); start = 1'b0; run(2);
    checks++;
    if (rdlog.size() !== 0 || busy_hi !== 0) begin
      errors++; $display("FAIL empty_start: got %0d strobes busy %0d cycles want 0/0", rdlog.size(), busy_hi);
    end
    fq.push_back(rand_tile()); fifo_empty = 1'b0;
    run(5);
    checks++;
    if (rdlog.size() !== 0 || busy_hi !== 0) begin
      errors++; $display("FAIL empty_nostart: got %0d strobes busy %0d cycles want 0/0", rdlog.size(), busy_hi);
    end
  endtask

  task automatic test_backpressure();
    logic [TILE_W-1:0] t;
    int c, cm, held;
    clr_logs();
    t = fq[0];
    pat = '{1, 1, 0, 0, 0};
    base = cyc + 3;
    pulse_start(c);
    model_load(c, t, cm);
    run(18);
    held = 0;
    foreach (vlog[i]) if (vlog[i].idx == 5) held++;
    checks++;
    if (held !== 4) begin
      errors++; $display("FAIL bp_hold: got row5 on %0d cycles want 4", held);
    end
    foreach (vexp[i]) begin
      checks++;
      if (i >= vlog.size() || vlog[i].cyc !== vexp[i].cyc || vlog[i].idx !== vexp[i].idx || vlog[i].row !== vexp[i].row) begin
        errors++; $display("FAIL bp_row%0d: got idx %0d want cyc %0d idx %0d",
                           i, (i < vlog.size()) ? vlog[i].idx : -1, vexp[i].cyc, vexp[i].idx);
      end
    end
    checks++;
    if (cmlog.size() !== 1 || cmlog[0] !== c + 14) begin
      errors++; $display("FAIL bp_commit: got %0d pulses at %0d want 1 at %0d", cmlog.size(), cmlog[0], c + 14);
    end
    pat.delete();
  endtask

  task automatic test_start_busy();
    logic [TILE_W-1:0] t;
    int c, cm;
    clr_logs();
    fq.push_back(rand_tile()); fq.push_back(rand_tile()); fifo_empty = 1'b0;
    t = fq[0];
    pat.delete();
    for (int i = 0; i < 12; i++) pat.push_back($urandom_range(0, 3) != 0);
    base = cyc + 3;
    pulse_start(c);
    model_load(c, t, cm);
    run(3);
    for (int i = 0; i < 6; i++) begin start = (i % 2 == 0); step(); end
    start = 1'b0;
    run(24);
    checks++;
    if (rdlog.size() !== 1) begin
      errors++; $display("FAIL busy_rd: got %0d strobes want 1", rdlog.size());
    end
    checks++;
    if (cmlog.size() !== 1 || cmlog[0] !== cm) begin
      errors++; $display("FAIL busy_commit: got %0d pulses at %0d want 1 at %0d", cmlog.size(), cmlog[0], cm);
    end
    checks++;
    if (vlog.size() !== vexp.size()) begin
      errors++; $display("FAIL busy_rows: got %0d valid cycles want %0d", vlog.size(), vexp.size());
    end
    foreach (vexp[i]) begin
      checks++;
      if (i >= vlog.size() || vlog[i].cyc !== vexp[i].cyc || vlog[i].idx !== vexp[i].idx || vlog[i].row !== vexp[i].row) begin
        errors++; $display("FAIL busy_row%0d: got idx %0d want cyc %0d idx %0d",
                           i, (i < vlog.size()) ? vlog[i].idx : -1, vexp[i].cyc, vexp[i].idx);
      end
    end
    pat.delete();
  endtask

  task automatic test_reset_mid();
    logic [TILE_W-1:0] t;
    int c, cm;
    clr_logs();
    fq.push_back(rand_tile()); fifo_empty = 1'b0;
    pulse_start(c);
    run(6);
    checks++;
    if (w_row_valid !== 1'b1 || w_row_idx !== IDX_W'(3)) begin
      errors++; $display("FAIL rmid_pre: got valid %b idx %0d want 1/3", w_row_valid, w_row_idx);
    end
    rstn = 1'b0; start = 1'b1; w_ready = 1'b1;
    step();
    rstn = 1'b1; start = 1'b0;
    checks++;
    if ({fifo_rd_en, w_row_valid, w_commit, busy} !== 4'b0 || w_row_out !== '0 || w_row_idx !== '0) begin
      errors++; $display("FAIL rmid_out: got ctrl %b row %h idx %0d want all 0",
                         {fifo_rd_en, w_row_valid, w_commit, busy}, w_row_out, w_row_idx);
    end
    run(5);
    checks++;
    if (cmlog.size() !== 0 || rdlog.size() !== 1) begin
      errors++; $display("FAIL rmid_abort: got %0d commits %0d strobes want 0/1", cmlog.size(), rdlog.size());
    end
    clr_logs();
    t = fq[0];
    pulse_start(c);
    model_load(c, t, cm);
    run(14);
    checks++;
    if (vlog.size() !== vexp.size() || vlog[0].row !== vexp[0].row || vlog[R-1].row !== vexp[R-1].row) begin
      errors++; $display("FAIL rmid_next: got %0d rows first %h want %0d rows first %h",
                         vlog.size(), vlog[0].row, vexp.size(), vexp[0].row);
    end
    checks++;
    if (cmlog.size() !== 1 || cmlog[0] !== cm) begin
      errors++; $display("FAIL rmid_commit: got %0d pulses at %0d want 1 at %0d", cmlog.size(), cmlog[0], cm);
    end
  endtask

  task automatic test_back_to_back();
    logic [TILE_W-1:0] a, b;
    int c1, c2, cm1, cm2, n;
    clr_logs();
    a = rand_tile(); b = rand_tile();
    fq.push_back(a); fq.push_back(b); fifo_empty = 1'b0;
    pat.delete();
    for (int i = 0; i < 10; i++) pat.push_back($urandom_range(0, 2) != 0);
    base = cyc + 3;
    pulse_start(c1);
    model_load(c1, a, cm1);
    n = 0;
    while (cmlog.size() == 0 && n < 40) begin step(); n++; end
    checks++;
    if (cmlog.size() == 0) begin
      errors++; $display("FAIL b2b_wait: got no commit in 40 cycles want one at %0d", cm1);
    end
    pat.delete();
    pulse_start(c2);
    model_load(c2, b, cm2);
    run(14);
    checks++;
    if (rdlog.size() !== 2 || rdlog[0] !== c1 + 1 || rdlog[1] !== c2 + 1 || c2 !== cm1 + 1) begin
      errors++; $display("FAIL b2b_rd: got %0d strobes at %0d,%0d want at %0d,%0d",
                         rdlog.size(), rdlog[0], rdlog[1], c1 + 1, cm1 + 2);
    end
    checks++;
    if (cmlog.size() !== 2 || cmlog[0] !== cm1 || cmlog[1] !== cm2) begin
      errors++; $display("FAIL b2b_commit: got %0d pulses at %0d,%0d want at %0d,%0d",
                         cmlog.size(), cmlog[0], cmlog[1], cm1, cm2);
    end
    checks++;
    if (vlog.size() !== vexp.size()) begin
      errors++; $display("FAIL b2b_rows: got %0d valid cycles want %0d", vlog.size(), vexp.size());
    end
    foreach (vexp[i]) begin
      if (i < vlog.size()) begin
        checks++;
        if (vlog[i].cyc !== vexp[i].cyc || vlog[i].idx !== vexp[i].idx || vlog[i].row !== vexp[i].row) begin
          errors++; $display("FAIL b2b_row%0d: got cyc %0d idx %0d want cyc %0d idx %0d",
                             i, vlog[i].cyc, vlog[i].idx, vexp[i].cyc, vexp[i].idx);
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; w_ready = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
    #1;
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
